lm32_dp_ram_ctrl: RTL
=====================

// Module: lm32_dp_ram_ctrl
// PURPOSE
//  Owns one lm32_dp_ram instance and sequences it. After reset or flush it zero-fills every entry, one per cycle.
//  In RUN it shares the single write port between two requesters (A, B) with round-robin arbitration.
//  It gates the read port and returns read data with a valid strobe.
//  Used as the shared storage controller for cache tag/data arrays in the CPU subsystem.
// PARAMETERS
//  addr_width  8   RAM address bits; depth = 2**addr_width; clear takes 2**addr_width cycles
//  data_width  32  RAM word width; clear writes {data_width{1'b0}}
// PORTS
//  clk_i        in   1   sole clock; all state on posedge
//  rst_i        in   1   synchronous, active-high reset
//  flush_i      in   1   request full zero-fill (restart clear)
//  busy_o       out  1   1 while in CLEAR (requesters stalled)
//  done_o       out  1   one-cycle pulse on the CLEAR->RUN transition
//  wa_req_i     in   1   requester A write request
//  wa_addr_i    in   AW  requester A write address
//  wa_data_i    in   DW  requester A write data
//  wa_ack_o     out  1   A granted; write commits this edge (combinational)
//  wb_req_i     in   1   requester B write request
//  wb_addr_i    in   AW  requester B write address
//  wb_data_i    in   DW  requester B write data
//  wb_ack_o     out  1   B granted; write commits this edge (combinational)
//  rd_req_i     in   1   read request
//  rd_addr_i    in   AW  read address
//  rd_ack_o     out  1   read accepted this cycle (combinational)
//  rd_valid_o   out  1   rd_data_o valid; registered, 1 cycle after rd_ack_o
//  rd_data_o    out  DW  read data (RAM output; meaningful only while rd_valid_o)
// BEHAVIOUR
//  Reset: state=CLEAR, clr_cnt=0, prio=A, rd_valid_o=0, done_o=0, busy_o=1, acks=0.
//  - Clear sequence starts automatically after reset.
//  CLEAR state:
//  - RAM we=1, waddr=clr_cnt, wdata=0; clr_cnt increments each cycle.
//  - All acks are 0; request inputs are ignored; requesters keep req high.
//  - When clr_cnt==all-ones: that zero write completes, next state=RUN, done_o=1 for one cycle, clr_cnt wraps to 0.
//  RUN state:
//  - busy_o=0.
//  - Exactly one of wa_ack_o/wb_ack_o is asserted when any req is high; RAM we = wa_ack_o|wb_ack_o.
//  - The RAM takes the address/data of the granted requester.
//  - Only one requester: it wins regardless of prio.
//  - Both requesters: the prio side wins. After any grant, prio = the non-granted side.
//  - prio is unchanged in cycles with no grant.
//  Read port:
//  - rd_ack_o = rd_req_i & (state==RUN); raddr=rd_addr_i.
//  - rd_valid_o <= rd_ack_o, so the latency is 1 cycle. Back-to-back reads give 1 result per cycle.
//  - Read and write to the same address in the same cycle return the NEW data (write-first).
//  flush_i:
//  - In RUN: the next state is CLEAR and clr_cnt=0. A write granted in the flush cycle still commits.
//  - In CLEAR: clr_cnt restarts at 0.
//  - flush_i takes precedence over the final-address exit, so done_o is suppressed.
//  rst_i mid-operation:
//  - Behaves as reset; any in-flight rd_valid_o is dropped (0 next cycle).
//  - RAM contents are not reset directly; the restarted clear overwrites them.
//  A read accepted in the last RUN cycle before CLEAR still returns rd_valid_o next cycle.
// STRUCTURE
//  Shared package lm32_dp_ram_ctrl_pkg:
//  - state encoding ST_CLEAR=1'b0, ST_RUN=1'b1.
//  - prio encoding PRIO_A=1'b0, PRIO_B=1'b1.
//  One sub-module: lm32_dp_ram (u_ram), instantiated with addr_width/data_width passed through.
//  Arbiter, state register and clear counter stay inline; no further hierarchy.
// TESTING  (addr_width=4, data_width=32 unless stated)
//  1 Reset release -> busy_o=1 for exactly 16 cycles, done_o pulses once, then busy_o=0; reads of addr 0..15 all return 0.
//  2 RUN, wa and wb both req every cycle, A addr=3 data=0xA, B addr=5 data=0xB:
//    -> acks alternate A,B,A,B starting with A; reading 3 and 5 gives 0xA and 0xB.
//  3 Only wb_req for 3 cycles after an A grant -> wb_ack_o=1 on all 3; prio stays B-side-consumed rule: next contention grants A.
//  4 rd_req addr=7 in the same cycle as wa write addr=7 data=0x1234 -> next cycle rd_valid_o=1, rd_data_o=0x1234.
//  5 flush_i in RUN after writing 0xFF to addr 9 -> busy_o=1 for 16 cycles, acks=0 throughout even with req held; addr 9 reads 0.
//  6 flush_i asserted at clr_cnt=10 during CLEAR -> clear restarts at 0, total busy 27 cycles, single done_o; rst_i at clr_cnt=5 -> same restart from 0.

Source files
------------

// File: rtl/lm32_dp_ram_ctrl_pkg.sv
// Shared encodings for the dual-port RAM controller: FSM state and write-arbiter priority.
package lm32_dp_ram_ctrl_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

   typedef enum logic {
      PRIO_A = 1'b0,
      PRIO_B = 1'b1
   } prio_e;

endpackage

// File: rtl/lm32_dp_ram.sv
// Simple dual-port RAM, one write and one registered read port, write-first on address collision.
// Contents are never reset; the controller zero-fills them.
module lm32_dp_ram #(
   parameter int addr_width = 8,
   parameter int data_width = 32
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [addr_width-1:0] waddr_i,
   input  logic [data_width-1:0] wdata_i,
   input  logic                  re_i,
   input  logic [addr_width-1:0] raddr_i,
   output logic [data_width-1:0] rdata_o
);

   logic [data_width-1:0] mem_q [0:(1<<addr_width)-1];
   logic [data_width-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      // Same-cycle write to the read address forwards the new word.
      if (re_i) begin
         rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/lm32_dp_ram_ctrl.sv
// Sequences one lm32_dp_ram: zero-fill after reset/flush, round-robin write arbitration
// between requesters A and B, gated read port with a 1-cycle registered valid strobe.
module lm32_dp_ram_ctrl
   import lm32_dp_ram_ctrl_pkg::*;
#(
   parameter int addr_width = 8,
   parameter int data_width = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   output logic                  busy_o,
   output logic                  done_o,
   input  logic                  wa_req_i,
   input  logic [addr_width-1:0] wa_addr_i,
   input  logic [data_width-1:0] wa_data_i,
   output logic                  wa_ack_o,
   input  logic                  wb_req_i,
   input  logic [addr_width-1:0] wb_addr_i,
   input  logic [data_width-1:0] wb_data_i,
   output logic                  wb_ack_o,
   input  logic                  rd_req_i,
   input  logic [addr_width-1:0] rd_addr_i,
   output logic                  rd_ack_o,
   output logic                  rd_valid_o,
   output logic [data_width-1:0] rd_data_o
);

   state_e                state_q, state_d;
   prio_e                 prio_q, prio_d;
   logic [addr_width-1:0] clr_cnt_q, clr_cnt_d;
   logic                  done_q, done_d;
   logic                  rd_valid_q;

   logic                  run;
   logic                  a_win, b_win;
   logic                  ram_we;
   logic [addr_width-1:0] ram_waddr;
   logic [data_width-1:0] ram_wdata;

   assign run   = (state_q == ST_RUN);
   assign a_win = run & wa_req_i & (~wb_req_i | (prio_q == PRIO_A));
   assign b_win = run & wb_req_i & (~wa_req_i | (prio_q == PRIO_B));

   assign ram_we    = ~run | a_win | b_win;
   assign ram_waddr = !run ? clr_cnt_q : (a_win ? wa_addr_i : wb_addr_i);
   assign ram_wdata = !run ? {data_width{1'b0}} : (a_win ? wa_data_i : wb_data_i);

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      prio_d    = prio_q;
      done_d    = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            // Flush outranks the final-address exit, so no done pulse on a restart.
            if (flush_i) begin
               clr_cnt_d = '0;
            end else if (clr_cnt_q == {addr_width{1'b1}}) begin
               state_d = ST_RUN;
               done_d  = 1'b1;
            end
         end
         ST_RUN: begin
            if (a_win) begin
               prio_d = PRIO_B;
            end else if (b_win) begin
               prio_d = PRIO_A;
            end
            if (flush_i) begin
               state_d   = ST_CLEAR;
               clr_cnt_d = '0;
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_CLEAR;
         clr_cnt_q  <= '0;
         prio_q     <= PRIO_A;
         done_q     <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_cnt_q  <= clr_cnt_d;
         prio_q     <= prio_d;
         done_q     <= done_d;
         rd_valid_q <= rd_ack_o;
      end
   end

   assign busy_o     = ~run;
   assign done_o     = done_q;
   assign wa_ack_o   = a_win;
   assign wb_ack_o   = b_win;
   assign rd_ack_o   = rd_req_i & run;
   assign rd_valid_o = rd_valid_q;

   lm32_dp_ram #(
      .addr_width(addr_width),
      .data_width(data_width)
   ) u_ram (
      .clk_i  (clk_i),
      .we_i   (ram_we),
      .waddr_i(ram_waddr),
      .wdata_i(ram_wdata),
      .re_i   (rd_ack_o),
      .raddr_i(rd_addr_i),
      .rdata_o(rd_data_o)
   );

endmodule
